fb_reader: RTL and testbench
============================

# fb_reader

Read side of the fractal frame buffer. Walks the VGA raster, turns each visible pixel coordinate into a 19-bit frame-buffer address, and fetches the stored 7-bit divergence count from the buffer's synchronous read port. It maps that count to 12-bit RGB and delays HS/VS/video_on so they stay aligned with the colour. It sits between `vga_sync` and the board's VGA pins, opposite the pipeline write port that fills the buffer.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible columns.
- `V_ACTIVE`, default 480: visible rows.
- `MAX_ITER`, default 100: count value meaning "never diverged" (in-set).

Ports:
- `Clk_100M` in 1: system clock.
- `reset` in 1: asynchronous active-low reset; 0 = reset.
- `pixel_tick` in 1: 25 MHz pixel strobe from `vga_sync`, one clock wide, every 4th clock.
- `video_on` in 1: visible-area flag from `vga_sync`.
- `pixel_x`, `pixel_y` in 10 each: raster coordinates from `vga_sync`.
- `hsync_in`, `vsync_in` in 1 each: raw syncs from `vga_sync`.
- `read_enable` in 1: frame buffer holds at least one complete frame.
- `addr_r` out 19: frame-buffer read address.
- `rd_en` out 1: frame-buffer read strobe.
- `dout` in 7: frame-buffer read data, valid 1 clock after `rd_en`.
- `HS`, `VS` out 1 each: aligned syncs.
- `COLOUR_OUT` out 12: RGB 4:4:4.
- `in_set_count` out 19: in-set pixels counted over the last completed frame.

## Operation
- **Frame gate.** `frame_live` samples `read_enable` only at a pixel_tick where `pixel_x==0` and `pixel_y==0`. A change of `read_enable` mid-frame has no effect until the next frame start. This prevents tearing.
- **S0 (address), on `pixel_tick`.**
  - If `video_on`, `pixel_x<H_ACTIVE`, `pixel_y<V_ACTIVE` and `frame_live`: `addr_r <= pixel_y*640 + pixel_x` (19-bit, no overflow for legal coordinates) and `rd_en <= 1`.
  - Otherwise `rd_en <= 0` and `addr_r` holds.
  - `rd_en` is high for exactly one clock per tick.
- **S1 (RAM).** `dout` is captured the clock after `rd_en`, together with a `valid` bit.
- **S2 (map).**
  - `valid` and `dout==MAX_ITER`: colour 12'h000.
  - `valid`, any other count: colour = palette(count).
  - Not `valid`: 12'h000.
  - The mapped value is registered into `COLOUR_OUT`.
- **Sync alignment.** `hsync_in` and `vsync_in` pass through the same 3-clock shift chain, so HS/VS/COLOUR_OUT change together.
- **Statistics.**
  - A 19-bit accumulator increments on every valid in-set pixel, saturating at 2^19-1.
  - On the first pixel_tick with `pixel_y==V_ACTIVE` (start of vertical blank), the accumulator value is copied to `in_set_count` and the accumulator is cleared.
  - If an in-set pixel coincides with the clear, the clear wins.
- **Reset values.** `addr_r`=0, `rd_en`=0, `COLOUR_OUT`=0, `HS`=1, `VS`=1, `in_set_count`=0, `frame_live`=0, pipeline valid bits=0. Reset mid-frame returns to these values immediately. Output resumes at the next frame start.

## Timing
- Latency from pixel_tick to `COLOUR_OUT` is 3 clocks: S0, then RAM read, then S2. This is less than the 4-clock pixel period, so there is no overlap between pixels.
- `dout` is consumed exactly 1 clock after `rd_en`. The RAM is never read while `rd_en` is 0.
- Read and write ports are independent. A same-address collision returns old or new data, and either is acceptable.
- HS/VS lag `hsync_in`/`vsync_in` by exactly 3 clocks.

## Configuration
- `FB_READER_PALETTE_EN` defined: palette is a 16-entry registered-constant RGB table indexed by `count[3:0]` (blue→cyan→yellow→red cycle). Mapping is combinational within S2.
- Not defined: greyscale with `g = count[6:3]` and `COLOUR_OUT = {g,g,g}`.
- Latency is 3 clocks in both builds.

## Structure
- Shared package `fractal_pkg` holds:
  - `H_ACTIVE_C`=640 and `V_ACTIVE_C`=480;
  - `FB_ADDR_W`=19 and `DIV_W`=7;
  - `rgb12_t` typedef (12-bit).
- The writer side uses the same constants.
- One sub-module, `colour_map`: count in, `rgb12_t` out, palette/greyscale selected by the macro.

## Test plan
- **Address mapping.** Reset released, `read_enable`=1 before frame start; tick at (0,0), (639,0), (0,1), (639,479) → `addr_r` = 0, 639, 640, 307199, each with a 1-clock `rd_en`.
- **In-set colour.** RAM model returns 100 at every address → `COLOUR_OUT`=12'h000 in all visible pixels. At the next y=480 tick, `in_set_count`=307200.
- **Greyscale and latency.** Greyscale build, `dout`=7'd80 → `COLOUR_OUT`=12'hAAA exactly 3 clocks after the tick. HS is delayed by the same 3 clocks.
- **Frame gate.** `read_enable` rises at pixel (100,200) → no `rd_en` for the rest of that frame, black output. Reads start at the next (0,0).
- **Blanking.** `video_on`=0 or x≥640 → `rd_en`=0, `COLOUR_OUT`=0, and the accumulator is unchanged.
- **Reset mid-line.** `reset`=0 at pixel (320,240) → all outputs at reset values within the same clock. After release, no output until the next frame start.

Source files
------------

// File: rtl/fractal_pkg.sv
// Constants and types shared by the frame-buffer reader and writer.
package fractal_pkg;

  localparam int H_ACTIVE_C = 640;
  localparam int V_ACTIVE_C = 480;
  localparam int FB_ADDR_W  = 19;
  localparam int DIV_W      = 7;

  typedef logic [11:0]          rgb12_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [DIV_W-1:0]     div_cnt_t;

  // Greyscale ramp: the top four bits of the count drive all three channels.
  function automatic rgb12_t grey12(input div_cnt_t count);
    return {count[6:3], count[6:3], count[6:3]};
  endfunction

endpackage

// File: rtl/fb_reader_if.sv
// Synchronous read port of the frame buffer: address/strobe out, data back one clock later.
interface fb_reader_if;
  import fractal_pkg::*;

  fb_addr_t addr_r;
  logic     rd_en;
  div_cnt_t dout;

  modport master (output addr_r, output rd_en, input  dout);
  modport slave  (input  addr_r, input  rd_en, output dout);

endinterface

// File: rtl/fb_reader_colour_map.sv
// Divergence count to RGB 4:4:4. FB_READER_PALETTE_EN selects the 16-entry palette,
// otherwise a greyscale ramp is produced.
module colour_map
  import fractal_pkg::*;
(
  input  div_cnt_t count_i,
  output rgb12_t   rgb_o
);

`ifdef FB_READER_PALETTE_EN
  // blue -> cyan -> yellow -> red, then back towards blue
  always_comb begin
    // NOTE: a default before the case keeps this purely combinational (no latch).
    rgb_o = '0;
    case (count_i[3:0])
      4'd0:  rgb_o = 12'h00F;
      4'd1:  rgb_o = 12'h05F;
      4'd2:  rgb_o = 12'h0AF;
      4'd3:  rgb_o = 12'h0FF;
      4'd4:  rgb_o = 12'h0FA;
      4'd5:  rgb_o = 12'h5F5;
      4'd6:  rgb_o = 12'hAF0;
      4'd7:  rgb_o = 12'hFF0;
      4'd8:  rgb_o = 12'hFC0;
      4'd9:  rgb_o = 12'hF80;
      4'd10: rgb_o = 12'hF40;
      4'd11: rgb_o = 12'hF00;
      4'd12: rgb_o = 12'hC03;
      4'd13: rgb_o = 12'h806;
      4'd14: rgb_o = 12'h409;
      4'd15: rgb_o = 12'h00C;
      default: rgb_o = '0;
    endcase
  end
`else
  assign rgb_o = grey12(count_i);
`endif

endmodule

// File: rtl/fb_reader.sv
// Frame-buffer read side: raster -> address -> RAM -> colour, syncs delayed to match.
// Colour mapping is selected by FB_READER_PALETTE_EN (see colour_map).
module fb_reader
  import fractal_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_C,
  parameter int V_ACTIVE = V_ACTIVE_C,
  parameter int MAX_ITER = 100
) (
  input  logic        Clk_100M,
  input  logic        reset,
  input  logic        pixel_tick,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        read_enable,
  fb_reader_if.master fb,
  output logic        HS,
  output logic        VS,
  output rgb12_t      COLOUR_OUT,
  output fb_addr_t    in_set_count
);

  localparam logic [9:0] H_LIM   = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM   = 10'(V_ACTIVE);
  localparam fb_addr_t   LINE_W  = fb_addr_t'(H_ACTIVE);
  localparam div_cnt_t   MAX_CNT = div_cnt_t'(MAX_ITER);

  fb_addr_t addr_q,  addr_d;
  logic     rd_en_q, rd_en_d;
  logic     valid_q, valid_d;
  rgb12_t   colour_q, colour_d;
  logic [2:0] hs_q, hs_d, vs_q, vs_d;
  fb_addr_t acc_q, acc_d;
  fb_addr_t in_set_count_q, in_set_count_d;
  logic     blank_seen_q, blank_seen_d;
  logic     frame_live_q, frame_live_d;

  logic     frame_start, live_now, read_ok, in_set, snap;
  fb_addr_t pixel_addr;
  rgb12_t   mapped;

  colour_map u_colour_map (
    .count_i (fb.dout),
    .rgb_o   (mapped)
  );

  // The frame-start tick itself already honours the freshly sampled read_enable.
  assign frame_start = pixel_tick && (pixel_x == '0) && (pixel_y == '0);
  assign live_now    = frame_start ? read_enable : frame_live_q;
  assign read_ok     = video_on && (pixel_x < H_LIM) && (pixel_y < V_LIM) && live_now;
  assign pixel_addr  = fb_addr_t'(pixel_y) * LINE_W + fb_addr_t'(pixel_x);

  assign in_set = valid_q && (fb.dout == MAX_CNT);
  assign snap   = pixel_tick && (pixel_y == V_LIM) && !blank_seen_q;

  always_comb begin
    frame_live_d   = frame_start ? read_enable : frame_live_q;
    addr_d         = addr_q;
    rd_en_d        = 1'b0;
    if (pixel_tick && read_ok) begin
      addr_d  = pixel_addr;
      rd_en_d = 1'b1;
    end

    valid_d  = rd_en_q;
    colour_d = (valid_q && !in_set) ? mapped : '0;
    hs_d     = {hs_q[1:0], hsync_in};
    vs_d     = {vs_q[1:0], vsync_in};

    blank_seen_d   = pixel_tick ? (pixel_y == V_LIM) : blank_seen_q;
    in_set_count_d = in_set_count_q;
    acc_d          = acc_q;
    if (snap) begin
      in_set_count_d = acc_q;
      acc_d          = '0;
    end else if (in_set && (acc_q != '1)) begin
      acc_d = acc_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk_100M or negedge reset) begin
    if (!reset) begin
      frame_live_q   <= 1'b0;
      addr_q         <= '0;
      rd_en_q        <= 1'b0;
      valid_q        <= 1'b0;
      colour_q       <= '0;
      hs_q           <= '1;
      vs_q           <= '1;
      acc_q          <= '0;
      in_set_count_q <= '0;
      blank_seen_q   <= 1'b0;
    end else begin
      frame_live_q   <= frame_live_d;
      addr_q         <= addr_d;
      rd_en_q        <= rd_en_d;
      valid_q        <= valid_d;
      colour_q       <= colour_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      acc_q          <= acc_d;
      in_set_count_q <= in_set_count_d;
      blank_seen_q   <= blank_seen_d;
    end
  end

  assign fb.addr_r    = addr_q;
  assign fb.rd_en     = rd_en_q;
  assign COLOUR_OUT   = colour_q;
  assign HS           = hs_q[2];
  assign VS           = vs_q[2];
  assign in_set_count = in_set_count_q;

endmodule

// File: tb/tb_fb_reader.sv
// Scoreboard bench for fb_reader: a driver issues pixel ticks and queues expectations,
// a monitor compares them against the DUT on the falling clock edge.
module tb_fb_reader;
  import fractal_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pixel_tick, video_on, hsync_in, vsync_in, read_enable;
  logic [9:0] pixel_x, pixel_y;
  logic       HS, VS;
  rgb12_t     colour;
  fb_addr_t   in_set_count;

  fb_reader_if fb_bus ();

  fb_reader dut (
    .Clk_100M     (clk),
    .reset        (rst_n),
    .pixel_tick   (pixel_tick),
    .video_on     (video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .read_enable  (read_enable),
    .fb           (fb_bus),
    .HS           (HS),
    .VS           (VS),
    .COLOUR_OUT   (colour),
    .in_set_count (in_set_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-buffer contents as a function of address, selected per test phase.
  int mem_mode = 0;
  function automatic logic [6:0] mem_val(input int a);
    case (mem_mode)
      0:       return 7'd100;
      1:       return 7'd80;
      default: return 7'((a * 7 + a / 640) % 101);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n)             fb_bus.dout <= '0;
    else if (fb_bus.rd_en)  fb_bus.dout <= mem_val(int'(fb_bus.addr_r));

  typedef enum {K_S0, K_GAP, K_COL, K_IDLE} kind_e;
  typedef struct {
    int       due;
    kind_e    kind;
    logic     rd;
    fb_addr_t addr;
    rgb12_t   col;
    logic     hs;
    logic     vs;
    logic     chk_stat;
    fb_addr_t stat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model state: frame gate, statistics, last issued address, current syncs.
  logic m_live = 1'b0;
  logic m_blank_seen = 1'b0;
  int   m_acc = 0;
  int   m_addr = 0;
  logic cur_hs = 1'b1;
  logic cur_vs = 1'b1;

  function automatic rgb12_t model_colour(input logic [6:0] v);
    logic [3:0] g;
    g = 4'(v / 8);
    return (v == 7'd100) ? 12'h000 : {g, g, g};
  endfunction

  task automatic tick(input int x, input int y, input logic vo, input logic hs, input logic vs);
    exp_t       e;
    logic       vis;
    logic [6:0] v;
    @(negedge clk);
    if (x == 0 && y == 0) m_live = read_enable;
    vis = vo && (x < 640) && (y < 480) && m_live;
    if (vis) m_addr = y * 640 + x;
    v = mem_val(y * 640 + x);

    e.due = cyc + 1; e.kind = K_S0; e.rd = vis; e.addr = fb_addr_t'(m_addr);
    e.col = '0; e.hs = cur_hs; e.vs = cur_vs; e.chk_stat = 1'b0; e.stat = '0;
    if (y == 480 && !m_blank_seen) begin
      e.chk_stat = 1'b1;
      e.stat     = fb_addr_t'(m_acc);
      m_acc      = 0;
    end
    m_blank_seen = (y == 480);
    if (vis && v == 7'd100) m_acc++;
    exp_q.push_back(e);

    e.due = cyc + 2; e.kind = K_GAP; e.chk_stat = 1'b0;
    exp_q.push_back(e);
    e.due = cyc + 3; e.kind = K_COL; e.col = vis ? model_colour(v) : 12'h000; e.hs = hs; e.vs = vs;
    exp_q.push_back(e);
    e.due = cyc + 4; e.kind = K_IDLE; e.col = 12'h000;
    exp_q.push_back(e);

    pixel_x = 10'(x); pixel_y = 10'(y); video_on = vo;
    hsync_in = hs; vsync_in = vs; pixel_tick = 1'b1;
    cur_hs = hs; cur_vs = vs;
    @(negedge clk);
    pixel_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic rand_visible(input int n);
    for (int i = 0; i < n; i++)
      tick($urandom_range(0, 639), $urandom_range(1, 479), ($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic rand_blank(input int n);
    for (int i = 0; i < n; i++)
      tick($urandom_range(640, 799), $urandom_range(1, 479), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"},  fb_bus.rd_en,  1'b0);
    check({tag, "_addr"},   fb_bus.addr_r, 0);
    check({tag, "_colour"}, colour,        0);
    check({tag, "_hs"},     HS,            1'b1);
    check({tag, "_vs"},     VS,            1'b1);
    check({tag, "_count"},  in_set_count,  0);
  endtask

  // Monitor: pops every expectation that falls due on this falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("sb_due_cycle", e.due, cyc);
        case (e.kind)
          K_S0: begin
            check("rd_en_tick", fb_bus.rd_en, e.rd);
            check("addr_r", fb_bus.addr_r, e.addr);
            if (e.chk_stat) check("in_set_count", in_set_count, e.stat);
          end
          K_GAP: begin
            check("rd_en_one_clock", fb_bus.rd_en, 1'b0);
            check("hs_before", HS, e.hs);
            check("vs_before", VS, e.vs);
          end
          K_COL: begin
            check("colour", colour, e.col);
            check("hs_aligned", HS, e.hs);
            check("vs_aligned", VS, e.vs);
          end
          default: check("colour_idle", colour, e.col);
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; pixel_tick = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; read_enable = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Frame 1: every stored count is MAX_ITER, so all output is black and all reads count.
    mem_mode = 0;
    tick(0, 0, 1'b1, 1'b1, 1'b0);
    tick(639, 0, 1'b1, 1'b0, 1'b1);
    tick(0, 1, 1'b1, 1'b1, 1'b1);
    rand_visible(40);
    rand_blank(10);
    tick(639, 479, 1'b1, 1'b1, 1'b1);
    tick(0, 480, 1'b0, 1'b1, 1'b0);
    tick(7, 480, 1'b0, 1'b0, 1'b0);
    tick(0, 481, 1'b0, 1'b1, 1'b1);

    // Frame 2: count 80 maps to grey 0xAAA; nothing is in-set.
    mem_mode = 1;
    tick(0, 0, 1'b1, 1'b0, 1'b1);
    rand_visible(25);
    rand_blank(5);
    tick(320, 480, 1'b0, 1'b1, 1'b1);

    // Frame 3: read_enable low at frame start, raised mid-frame; stays dark until next frame.
    mem_mode = 2;
    read_enable = 1'b0;
    tick(0, 0, 1'b1, 1'b1, 1'b1);
    rand_visible(10);
    read_enable = 1'b1;
    tick(100, 200, 1'b1, 1'b0, 1'b1);
    rand_visible(10);
    tick(0, 480, 1'b0, 1'b1, 1'b1);

    // Frame 4: reads resume with mixed counts.
    tick(0, 0, 1'b1, 1'b1, 1'b1);
    rand_visible(50);
    rand_blank(5);
    tick(0, 480, 1'b0, 1'b1, 1'b1);
    tick(0, 0, 1'b1, 1'b1, 1'b1);
    rand_visible(5);
    @(negedge clk);

    // Reset asserted mid-line just after a read is issued at (320,240).
    pixel_x = 10'd320; pixel_y = 10'd240; video_on = 1'b1; pixel_tick = 1'b1;
    @(negedge clk);
    pixel_tick = 1'b0;
    check("pre_reset_rd_en", fb_bus.rd_en, 1'b1);
    check("pre_reset_addr", fb_bus.addr_r, 240 * 640 + 320);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midline");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_live = 1'b0; m_blank_seen = 1'b0; m_acc = 0; m_addr = 0;
    hsync_in = 1'b1; vsync_in = 1'b1; cur_hs = 1'b1; cur_vs = 1'b1;
    repeat (4) @(negedge clk);
    tick(321, 240, 1'b1, 1'b0, 1'b1);
    rand_visible(5);
    tick(0, 480, 1'b0, 1'b1, 1'b1);
    tick(0, 0, 1'b1, 1'b1, 1'b1);
    rand_visible(10);

    repeat (8) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
